// File: rtl/rr_req_agent.sv
// rtl/rr_req_agent.sv - per-client request agent in front of a 16-way round-robin arbiter
//
// Purpose: tracks up to DEPTH outstanding requests per client, presents the
// request vector to the arbiter, retires one request per consumed grant and
// flags overflow, starvation and illegal grants.
//
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   push[15:0]   - per-client enqueue pulse
//   gnt[15:0]    - one-hot grant from the arbiter
//   clr_starve   - per-client clear of the sticky starve flag
//   req[15:0]    - request vector to the arbiter (combinational)
//   full[15:0]   - client pending count equals DEPTH (combinational)
//   done[15:0]   - one-cycle pulse after a consumed grant
//   starve[15:0] - sticky: client waited TIMEOUT or more cycles
//   ovf[15:0]    - sticky: a push was dropped because the client was full
//   err_gnt      - one-cycle pulse after a non-one-hot grant or a grant to an empty client
module rr_req_agent #(
  parameter int DEPTH   = 7,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] push,
  input  logic [15:0] gnt,
  input  logic [15:0] clr_starve,
  output logic [15:0] req,
  output logic [15:0] full,
  output logic [15:0] done,
  output logic [15:0] starve,
  output logic [15:0] ovf,
  output logic        err_gnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [7:0]    C_WAITMAX = 8'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt  [16];
  logic [7:0]    r_wcnt [16];
  logic [15:0]   r_done;
  logic [15:0]   r_starve;
  logic [15:0]   r_ovf;
  logic          r_err_gnt;

  logic [15:0] w_nonempty;
  logic [15:0] w_full;
  logic [15:0] w_req;
  logic [15:0] w_consume;
  logic [15:0] w_push_ok;
  logic [15:0] w_drop;
  logic        w_multi;
  logic        w_err;

  // More than one grant bit set: x & (x-1) clears the lowest set bit.
  assign w_multi = |(gnt & (gnt - 16'd1));
  assign w_err   = w_multi | (|(gnt & ~w_nonempty));

  always_comb begin
    w_nonempty = '0;
    w_full     = '0;
    w_req      = '0;
    w_consume  = '0;
    w_push_ok  = '0;
    w_drop     = '0;
    for (int i = 0; i < 16; i++) begin
      w_nonempty[i] = (r_cnt[i] != '0);
      w_full[i]     = (r_cnt[i] == C_DEPTH);
      // A granted client hides its last pending request so the arbiter
      // cannot re-grant it in the following cycle.
      w_req[i]      = (r_cnt[i] > (gnt[i] ? CW'(1) : CW'(0)));
      w_consume[i]  = gnt[i] & w_nonempty[i] & ~w_multi;
      // A push into a full client fits only if a slot frees in the same cycle.
      w_push_ok[i]  = push[i] & (~w_full[i] | w_consume[i]);
      w_drop[i]     = push[i] & w_full[i] & ~w_consume[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_cnt[i]  <= '0;
        r_wcnt[i] <= '0;
      end
      r_done    <= '0;
      r_starve  <= '0;
      r_ovf     <= '0;
      r_err_gnt <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        // A non-one-hot grant freezes every pending count for that cycle.
        if (!w_multi) begin
          if (w_push_ok[i] && !w_consume[i]) begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end else if (w_consume[i] && !w_push_ok[i]) begin
            r_cnt[i] <= r_cnt[i] - CW'(1);
          end
        end

        if (!w_req[i] || w_consume[i]) begin
          r_wcnt[i] <= '0;
        end else if (r_wcnt[i] != 8'hff) begin
          r_wcnt[i] <= r_wcnt[i] + 8'd1;
        end

        // Set has priority over clear.
        if (w_req[i] && !w_consume[i] && (r_wcnt[i] == C_WAITMAX)) begin
          r_starve[i] <= 1'b1;
        end else if (clr_starve[i]) begin
          r_starve[i] <= 1'b0;
        end

        if (w_drop[i]) begin
          r_ovf[i] <= 1'b1;
        end
      end
      r_done    <= w_consume;
      r_err_gnt <= w_err;
    end
  end

  assign req     = w_req;
  assign full    = w_full;
  assign done    = r_done;
  assign starve  = r_starve;
  assign ovf     = r_ovf;
  assign err_gnt = r_err_gnt;

endmodule

// File: doc/rr_req_agent.md
RR_REQ_AGENT -- requirements
Module: rr_req_agent

Interface
REQ-001 SHALL have parameter DEPTH, default 7, meaning the maximum outstanding requests per client (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the wait cycles before a starvation flag is set (legal range 2..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port push, input, 16 bits: per-client pulse that enqueues one request for client i.
REQ-006 SHALL have port gnt, input, 16 bits: one-hot grant vector from the 16-way round-robin arbiter.
REQ-007 SHALL have port clr_starve, input, 16 bits: per-client clear for the starve flag.
REQ-008 SHALL have port req, output, 16 bits: request vector driven to the arbiter.
REQ-009 SHALL have port full, output, 16 bits: client i pending count equals DEPTH.
REQ-010 SHALL have port done, output, 16 bits: registered one-cycle pulse when a grant to client i is consumed.
REQ-011 SHALL have port starve, output, 16 bits: sticky flag set when client i waits TIMEOUT or more cycles without a grant.
REQ-012 SHALL have port ovf, output, 16 bits: sticky flag set when a push is dropped because client i is full.
REQ-013 SHALL have port err_gnt, output, 1 bit: registered one-cycle pulse on an illegal grant.

Function
REQ-014 SHALL keep, per client, a pending counter cnt_i of width $clog2(DEPTH+1), plus a wait counter wcnt_i of 8 bits.
REQ-015 SHALL define each client state as IDLE when cnt_i==0, PEND when 0<cnt_i<DEPTH, and FULL when cnt_i==DEPTH; the state is derived from cnt_i with no separate state register.
REQ-016 SHALL consume a grant only when gnt[i]=1 and cnt_i>0.
REQ-017 SHALL update cnt_i each cycle as follows:
- push and no consumed grant: cnt_i+1.
- consumed grant and no push: cnt_i-1.
- both push and consumed grant: cnt_i unchanged.
REQ-018 SHALL drop a push when cnt_i==DEPTH and no grant is consumed that cycle, and set ovf[i] on the next edge.
REQ-019 SHALL accept a push in the FULL state when a grant is consumed in the same cycle; cnt_i stays DEPTH and ovf is not set.
REQ-020 SHALL drive req[i] combinationally as (cnt_i > (gnt[i] ? 1 : 0)), so req drops in the cycle the last pending grant is consumed and the arbiter cannot issue a spurious back-to-back grant.
REQ-021 SHALL assert done[i] for exactly one cycle, on the edge after a consumed grant.
REQ-022 SHALL assert err_gnt for one cycle, on the next edge, if gnt has more than one bit set, or if gnt[i]=1 while cnt_i==0.
REQ-023 SHALL not modify any cnt_i in an error cycle caused by a non-one-hot gnt; for a one-hot gnt to an empty client, nothing is decremented.
REQ-024 SHALL handle wcnt_i as follows:
- clear to 0 when req[i]=0 or on a consumed grant.
- otherwise increment, saturating at 255.
REQ-025 SHALL set starve[i] on the edge where wcnt_i reaches TIMEOUT-1 and increments.
REQ-026 SHALL clear starve[i] only on clr_starve[i]=1; if set and clear coincide, set wins.
REQ-027 SHALL clear ovf[i] only on reset.
REQ-028 SHALL drive full[i] combinationally as (cnt_i==DEPTH).
REQ-029 SHALL exhibit 1-cycle latency from push to req assertion, with req rising after the edge that captures the push.

Reset
REQ-030 SHALL, on rst_n=0, asynchronously clear all cnt_i, wcnt_i, done, starve, ovf and err_gnt to 0; req and full are then 0.
REQ-031 SHALL, on reset asserted mid-operation, discard all pending requests with no done pulse; release is synchronous to the next clk rising edge.

Verification
REQ-032 Bench SHALL cover: single push[3] -> req[3]=1 the next cycle; gnt[3] one cycle later -> req[3]=0 the same cycle, done[3]=1 the following cycle, cnt_3=0.
REQ-033 Bench SHALL cover: 8 pushes to client 5 with DEPTH=7 and no grants -> full[5]=1 after the 7th push, ovf[5]=1 after the 8th, cnt_5=7.
REQ-034 Bench SHALL cover: client 9 FULL, push[9] and gnt[9] in the same cycle -> cnt_9 stays 7, ovf[9]=0, done[9] pulses.
REQ-035 Bench SHALL cover: push[0] with gnt held 0 for 64 cycles -> starve[0]=1 after cycle 64; clr_starve[0] -> starve[0]=0 the next cycle.
REQ-036 Bench SHALL cover: gnt=16'h0006, then gnt=16'h0100 with cnt_8=0 -> err_gnt pulses on each, and no counter changes.
REQ-037 Bench SHALL cover: rst_n driven low with 3 clients pending -> req=0 immediately (asynchronously), and no done pulse after release.
